fpadd_arbiter: RTL and testbench
================================

Name: fpadd_arbiter

Overview:
Shares one single-precision floating-point adder (fpadd) among NREQ requesters. Grants requests round-robin, latches the granted operands, sequences the adder's start/done handshake, and returns the sum tagged with the requester ID. A watchdog bounds how long an operation may run. On timeout, the block resets the adder and returns an error response.

Parameters:
NREQ, 4, number of requesters (2..16)
TIMEOUT, 64, max cycles in WAIT before the watchdog fires (>=4)
IDW, $clog2(NREQ), requester ID width (derived, not overridable)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester operation request
req_a  in  NREQ*32  operand A, requester i at [32i+31:32i]
req_b  in  NREQ*32  operand B, same packing
req_ready  out  NREQ  one-hot accept pulse
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  requester ID of the response
rsp_sum  out  32  IEEE-754 result
rsp_err  out  1  1 = watchdog timeout
fa_reset  out  1  adder reset = reset OR flush_active (combinational)
fa_start  out  1  adder start
fa_a  out  32  adder operand A
fa_b  out  32  adder operand B
fa_sum  in  32  adder result
fa_done  in  1  adder completion, sampled only in ISSUE/WAIT

Behaviour:
- Reset values (async):
  - state=IDLE, ptr=0, timer=0, flush count=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_err=0.
  - fa_start=0, fa_a=0, fa_b=0, req_ready=0.
  - fa_reset=1 while reset is high.
- States: IDLE, ISSUE, WAIT, FLUSH, RESP. Encoded in 3 bits.
- IDLE:
  - Search req_valid starting at index ptr, wrapping modulo NREQ.
  - On the first hit g: req_ready[g]=1 for this cycle only (combinational, one-hot); latch req_a/req_b slice g into fa_a/fa_b; latch id=g; next state ISSUE.
  - No hit: stay in IDLE, req_ready=0.
- ISSUE:
  - fa_start=1 for exactly this one cycle.
  - fa_done=1 in this same cycle (the adder's special-operand path) is a valid completion: capture fa_sum into rsp_sum, rsp_err=0, next state RESP.
  - Otherwise: timer=0, next state WAIT.
- WAIT:
  - fa_start=0; fa_a/fa_b held stable.
  - fa_done=1: capture fa_sum, rsp_err=0, next state RESP.
  - Otherwise timer increments. When timer==TIMEOUT-1 with no done: rsp_sum=32'h7FC00000, rsp_err=1, next state FLUSH.
  - fa_done seen in the same cycle as timer==TIMEOUT-1 wins (no error).
- FLUSH:
  - fa_reset=1 for exactly 2 cycles, then RESP.
  - fa_done is ignored.
- RESP:
  - rsp_valid=1; rsp_id/rsp_sum/rsp_err held stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid=0 next cycle, ptr=(id+1) mod NREQ, next state IDLE.
  - No request is granted while in RESP.
- fa_done outside ISSUE/WAIT is ignored; a stale high done never produces a response.
- Throughput: at most one operation in flight.
  - Minimum turnaround is 3 cycles per op (IDLE, ISSUE, RESP with rsp_ready=1 and done in ISSUE).
  - A normal op of k adder cycles takes k+3 cycles.
- Fairness: a continuously requesting requester is granted within NREQ operations.
- req_valid dropped before grant: no action. Requester operands must be stable while req_valid=1.
- Async reset mid-operation: the in-flight operation is discarded, no response is issued, and ptr returns to 0.

Test Plan:
- Requester 1 only: a=32'h3F800000 (1.0), b=32'h40000000 (2.0); adder model takes 6 cycles -> req_ready[1] pulses once; fa_start high 1 cycle; rsp_valid with rsp_id=1, rsp_sum=32'h40400000, rsp_err=0 exactly 9 cycles after grant.
- Requester 2: a=0, b=32'h40400000; model asserts fa_done in the start cycle -> rsp_sum=32'h40400000, rsp_id=2, rsp_valid in the cycle after ISSUE.
- All 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; each req_ready one-hot; no two grants without an intervening response.
- Adder model never asserts done, TIMEOUT=64 -> rsp_err=1, rsp_sum=32'h7FC00000; fa_reset high exactly 2 cycles beginning 65 cycles after ISSUE; the next request then completes normally.
- rsp_ready held low 5 cycles with a response pending and req_valid=4'b1111 -> rsp_* stable, req_ready stays 0, grant occurs only after the handshake.
- Assert reset asynchronously (between clk edges) during WAIT -> rsp_valid, fa_start, fa_a/fa_b go 0 immediately; fa_reset=1; after release the arbiter is in IDLE with ptr=0 and no stale response.

Source files
------------

// File: rtl/fpadd_arbiter_if.sv
// rtl/fpadd_arbiter_if.sv - requester, response and adder-side signals of the shared fpadd arbiter
interface fpadd_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_sum;
    logic               rsp_err;
    logic               fa_reset;
    logic               fa_start;
    logic [31:0]        fa_a;
    logic [31:0]        fa_b;
    logic [31:0]        fa_sum;
    logic               fa_done;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, fa_sum, fa_done,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err,
        input  fa_reset, fa_start, fa_a, fa_b
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, fa_sum, fa_done,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err,
        output fa_reset, fa_start, fa_a, fa_b
    );
endinterface

// File: rtl/fpadd_arbiter.sv
// rtl/fpadd_arbiter.sv - round-robin sharing of one fpadd among NREQ requesters with a watchdog
module fpadd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    fpadd_arbiter_if.slave       bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] IDMAX = IDW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FLUSH = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [TW-1:0]   r_timer;
    logic            r_flush_cnt;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_sum;
    logic            r_rsp_err;
    logic            r_fa_start;
    logic [31:0]     r_fa_a;
    logic [31:0]     r_fa_b;

    logic            w_hit;
    logic [IDW-1:0]  w_gnt;
    int              w_idx;

    // First requester at or after r_ptr, wrapping modulo NREQ
    always_comb begin
        w_hit = 1'b0;
        w_gnt = '0;
        w_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_hit && bus.req_valid[w_idx]) begin
                w_hit = 1'b1;
                w_gnt = IDW'(w_idx);
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE && w_hit && !reset) ? (NREQ'(1) << w_gnt) : '0;
    assign bus.fa_reset  = reset | (r_state == S_FLUSH);
    assign bus.fa_start  = r_fa_start;
    assign bus.fa_a      = r_fa_a;
    assign bus.fa_b      = r_fa_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_err   = r_rsp_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_timer     <= '0;
            r_flush_cnt <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_err   <= 1'b0;
            r_fa_start  <= 1'b0;
            r_fa_a      <= '0;
            r_fa_b      <= '0;
        end else begin
            r_fa_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_fa_a     <= bus.req_a[{w_gnt, 5'd0} +: 32];
                        r_fa_b     <= bus.req_b[{w_gnt, 5'd0} +: 32];
                        r_id       <= w_gnt;
                        r_fa_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Special operands may complete in the start cycle itself
                    if (bus.fa_done) begin
                        r_rsp_sum   <= bus.fa_sum;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.fa_done) begin
                        r_rsp_sum   <= bus.fa_sum;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_timer == TLAST) begin
                        r_rsp_sum   <= 32'h7FC0_0000;
                        r_rsp_err   <= 1'b1;
                        r_flush_cnt <= 1'b0;
                        r_state     <= S_FLUSH;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_flush_cnt <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= (r_id == IDMAX) ? '0 : r_id + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb/tb_fpadd_arbiter.sv - scoreboard bench for fpadd_arbiter with a behavioural adder model
module tb_fpadd_arbiter;
    localparam int NREQ     = 4;
    localparam int TIMEOUT  = 64;
    localparam int ADD_BUSY = 6;

    logic clk;
    logic reset;
    fpadd_arbiter_if #(.NREQ(NREQ)) bus ();

    fpadd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_tests  = 0;
    int n_failed = 0;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        err;
    } exp_t;
    exp_t sb[$];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(string nm);
        n_tests++;
        n_failed++;
        $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
    endtask

    task automatic push_exp(int id, logic [31:0] s, logic e);
        exp_t x;
        x.id  = id;
        x.sum = s;
        x.err = e;
        sb.push_back(x);
    endtask

    function automatic logic [31:0] add_tbl(logic [31:0] a, logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h0000_0000, 32'h4040_0000}: return 32'h4040_0000;
            {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
            {32'h3F00_0000, 32'h3F00_0000}: return 32'h3F80_0000;
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Adder model: 0 = done after ADD_BUSY idle cycles, 1 = done in start cycle, 2 = never, 3 = stuck high
    int mode = 0;
    int add_cnt = 0;
    always @(negedge clk) begin
        bus.fa_sum = add_tbl(bus.fa_a, bus.fa_b);
        if (bus.fa_reset) begin
            add_cnt     = 0;
            bus.fa_done = 1'b0;
        end else begin
            case (mode)
                1: bus.fa_done = bus.fa_start;
                2: bus.fa_done = 1'b0;
                3: bus.fa_done = 1'b1;
                default: begin
                    if (bus.fa_start) begin
                        add_cnt     = ADD_BUSY + 1;
                        bus.fa_done = 1'b0;
                    end else if (add_cnt > 0) begin
                        add_cnt     = add_cnt - 1;
                        bus.fa_done = (add_cnt == 0);
                    end else begin
                        bus.fa_done = 1'b0;
                    end
                end
            endcase
        end
    end

    int   start_cnt  = 0;
    int   last_start = 0;
    int   fr_cnt     = 0;
    int   fr_first   = 0;
    int   rsp_count  = 0;
    logic fr_prev    = 1'b1;
    logic outstanding = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            outstanding = 1'b0;
            fr_prev     = 1'b1;
        end else begin
            if (bus.fa_start) begin
                start_cnt++;
                last_start = cyc;
            end
            if (bus.fa_reset) begin
                if (!fr_prev) fr_first = cyc;
                fr_cnt++;
            end
            fr_prev = bus.fa_reset;
            if (bus.req_ready != '0) begin
                check("grant_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                check("grant_overlap", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_count++;
                outstanding = 1'b0;
                if (sb.size() == 0) begin
                    bound_fail("rsp_unexpected");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rsp_sum", bus.rsp_sum, e.sum);
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    // Call right after an @(negedge clk); returns at negedge+1 of the grant cycle
    task automatic wait_grant(output int gc, output logic [NREQ-1:0] gv);
        gc = -1;
        gv = '0;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (bus.req_ready != '0) begin
                gc = cyc;
                gv = bus.req_ready;
                return;
            end
            @(negedge clk);
        end
        bound_fail("grant_wait");
    endtask

    task automatic wait_rsp(output int rc);
        rc = -1;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (bus.rsp_valid) begin
                rc = cyc;
                return;
            end
            @(negedge clk);
        end
        bound_fail("rsp_wait");
    endtask

    int g, r, s0, f0, base, hs;
    logic [NREQ-1:0] gv;
    logic [31:0] hold_sum;

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_sum", bus.rsp_sum, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_fa_start", 32'(bus.fa_start), 32'd0);
        check("rst_fa_a", bus.fa_a, 32'd0);
        check("rst_fa_b", bus.fa_b, 32'd0);
        check("rst_fa_reset", 32'(bus.fa_reset), 32'd1);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);

        // Requester 1 alone, 1.0 + 2.0 through a multi-cycle adder
        @(negedge clk);
        reset = 1'b0;
        mode  = 0;
        set_req(1, 32'h3F80_0000, 32'h4000_0000);
        push_exp(1, 32'h4040_0000, 1'b0);
        s0 = start_cnt;
        bus.req_valid = 4'b0010;
        wait_grant(g, gv);
        check("t1_grant", 32'(gv), 32'h2);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(r);
        check("t1_latency", 32'(r - g), 32'd9);
        check("t1_start_pulses", 32'(start_cnt - s0), 32'd1);
        check("t1_start_cycle", 32'(last_start - g), 32'd1);

        // Requester 2, adder completes in the start cycle
        @(negedge clk);
        mode = 1;
        set_req(2, 32'h0000_0000, 32'h4040_0000);
        push_exp(2, 32'h4040_0000, 1'b0);
        bus.req_valid = 4'b0100;
        wait_grant(g, gv);
        check("t2_grant", 32'(gv), 32'h4);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(r);
        check("t2_latency", 32'(r - g), 32'd2);

        // Round robin from ptr=0 with all four requesting
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mode  = 0;
        set_req(0, 32'h3F80_0000, 32'h3F80_0000);
        set_req(1, 32'h3F80_0000, 32'h4000_0000);
        set_req(2, 32'h4000_0000, 32'h4000_0000);
        set_req(3, 32'h3F00_0000, 32'h3F00_0000);
        push_exp(0, 32'h4000_0000, 1'b0);
        push_exp(1, 32'h4040_0000, 1'b0);
        push_exp(2, 32'h4080_0000, 1'b0);
        push_exp(3, 32'h3F80_0000, 1'b0);
        push_exp(0, 32'h4000_0000, 1'b0);
        push_exp(1, 32'h4040_0000, 1'b0);
        base = rsp_count;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 1000 && rsp_count < base + 6; k++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        bus.req_valid = '0;
        if (rsp_count < base + 6) bound_fail("t3_rr_wait");

        // Watchdog: adder never finishes
        @(negedge clk);
        mode = 2;
        f0 = fr_cnt;
        push_exp(3, 32'h7FC0_0000, 1'b1);
        bus.req_valid = 4'b1000;
        wait_grant(g, gv);
        check("t4_grant", 32'(gv), 32'h8);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(r);
        check("t4_flush_start", 32'(fr_first - (g + 1)), 32'd65);
        check("t4_flush_len", 32'(fr_cnt - f0), 32'd2);
        check("t4_rsp_cycle", 32'(r - g), 32'd68);

        @(negedge clk);
        mode = 0;
        push_exp(0, 32'h4000_0000, 1'b0);
        bus.req_valid = 4'b0001;
        wait_grant(g, gv);
        check("t4_next_grant", 32'(gv), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(r);
        check("t4_next_latency", 32'(r - g), 32'd9);

        // Backpressure: response held while consumer stalls
        @(negedge clk);
        mode          = 1;
        bus.rsp_ready = 1'b0;
        push_exp(1, 32'h4040_0000, 1'b0);
        bus.req_valid = 4'b1111;
        wait_grant(g, gv);
        check("t5_grant", 32'(gv), 32'h2);
        @(negedge clk);
        wait_rsp(r);
        hold_sum = 32'h4040_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("t5_hold_id", 32'(bus.rsp_id), 32'd1);
            check("t5_hold_sum", bus.rsp_sum, hold_sum);
            check("t5_hold_err", 32'(bus.rsp_err), 32'd0);
            check("t5_hold_no_grant", 32'(bus.req_ready), 32'd0);
        end
        push_exp(2, 32'h4080_0000, 1'b0);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        hs = cyc;
        wait_grant(g, gv);
        check("t5_next_grant", 32'(gv), 32'h4);
        check("t5_grant_after_hs", 32'(g - hs), 32'd1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(r);

        // Asynchronous reset while the adder is busy
        @(negedge clk);
        mode = 0;
        bus.req_valid = 4'b0001;
        wait_grant(g, gv);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_fa_start", 32'(bus.fa_start), 32'd0);
        check("t6_fa_a", bus.fa_a, 32'd0);
        check("t6_fa_b", bus.fa_b, 32'd0);
        check("t6_fa_reset", 32'(bus.fa_reset), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_exp(0, 32'h4000_0000, 1'b0);
        bus.req_valid = 4'b1111;
        wait_grant(g, gv);
        check("t6_grant_ptr0", 32'(gv), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(r);

        // A done stuck high outside ISSUE/WAIT must not produce a response
        @(negedge clk);
        mode = 3;
        repeat (6) @(negedge clk);
        #1;
        check("stale_done_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        mode = 0;
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
